// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM,
// one-byte holding register with sticky overrun and framing flags.
module uart_rx #(
  parameter logic [11:0] BIT_TIME = 12'd433
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       overrun,
  output logic       ferr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  localparam logic [11:0] HALF = BIT_TIME >> 1;

  state_t      state;
  logic        rxd_m;
  logic        rxd_s;
  logic [11:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      rxd_m   <= 1'b1;
      rxd_s   <= 1'b1;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      dout    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      cnt   <= cnt + 12'd1;
      // read clears first; a completing frame below overrides it
      if (rd) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
        ferr    <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
              idx   <= '0;
            end
          end
        end
        S_DATA: begin
          if (cnt == BIT_TIME) begin
            cnt   <= '0;
            shift <= {rxd_s, shift[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt == BIT_TIME) begin
            cnt <= '0;
            if (rxd_s) begin
              dout  <= shift;
              valid <= 1'b1;
              if (valid && !rd) overrun <= 1'b1;
              state <= S_IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (rxd_s) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame driver with a queue-based scoreboard for uart_rx;
// the model tracks the holding register and flags per received frame.
module tb_uart_rx;

  localparam int BT = 434;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rxd;
  logic       rd;
  logic [7:0] dout;
  logic       valid;
  logic       overrun;
  logic       ferr;

  uart_rx dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rxd     (rxd),
    .rd      (rd),
    .dout    (dout),
    .valid   (valid),
    .overrun (overrun),
    .ferr    (ferr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       o;
    logic       f;
    int         t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] m_d = 8'h00;
  logic       m_v = 1'b0;
  logic       m_o = 1'b0;
  logic       m_f = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: a new byte shows as valid rising, dout changing or overrun rising
  initial begin
    logic [7:0] pd;
    logic       pv;
    logic       po;
    exp_t       e;
    int         lat;
    pd = 8'h00;
    pv = 1'b0;
    po = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && valid &&
          (!pv || dout != pd || (overrun && !po))) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_frame: got %0h expected none", dout);
        end else begin
          e = q.pop_front();
          chk("dout", int'(dout), int'(e.d));
          chk("overrun", int'(overrun), int'(e.o));
          chk("ferr", int'(ferr), int'(e.f));
          lat = cyc - e.t;
          n_cmp++;
          if (lat < 4125 || lat > 4127) begin
            n_bad++;
            $display("FAIL latency: got %0d expected 4126+/-1", lat);
          end
        end
      end
      pd = dout;
      pv = valid;
      po = overrun;
    end
  end

  task automatic model_rd();
    m_v = 1'b0;
    m_o = 1'b0;
    m_f = 1'b0;
  endtask

  task automatic do_rd();
    rd = 1'b1;
    wait_cycles(1);
    rd = 1'b0;
    model_rd();
    chk("rd_valid", int'(valid), 0);
    chk("rd_overrun", int'(overrun), 0);
    chk("rd_ferr", int'(ferr), 0);
  endtask

  // rst_bit >= 0 aborts the frame with a reset pulse inside that data bit
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input bit rd_done, input int rst_bit);
    exp_t e;
    int   ts;
    rxd = 1'b0;
    ts  = cyc;
    wait_cycles(BT);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      if (i == rst_bit) begin
        wait_cycles(200);
        reset_n = 1'b0;
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_ferr", int'(ferr), 0);
        rxd = 1'b1;
        model_rd();
        m_d = 8'h00;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(2 * BT);
        return;
      end
      wait_cycles(BT);
    end
    rxd = stop;
    if (rd_done) model_rd();
    if (stop) begin
      m_o = m_o | m_v;
      m_v = 1'b1;
      m_d = d;
      e.d = d;
      e.o = m_o;
      e.f = m_f;
      e.t = ts;
      q.push_back(e);
    end else begin
      m_f = 1'b1;
    end
    if (rd_done) begin
      wait_cycles(219);
      rd = 1'b1;
      wait_cycles(1);
      rd = 1'b0;
      wait_cycles(214);
    end else begin
      wait_cycles(BT);
    end
  endtask

  initial begin
    logic [7:0] r;
    reset_n = 1'b0;
    rxd     = 1'b1;
    rd      = 1'b0;
    wait_cycles(5);
    chk("reset_dout", int'(dout), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_ferr", int'(ferr), 0);
    reset_n = 1'b1;
    wait_cycles(10);

    send_frame(8'h55, 1'b1, 1'b0, -1);
    chk("valid_55", int'(valid), 1);
    do_rd();

    rxd = 1'b0;
    wait_cycles(100);
    rxd = 1'b1;
    wait_cycles(2 * BT);
    chk("glitch_valid", int'(valid), 0);
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    do_rd();

    send_frame(8'hA5, 1'b1, 1'b0, -1);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    chk("b2b_dout", int'(dout), 8'h3C);
    chk("b2b_overrun", int'(overrun), 1);
    do_rd();

    send_frame(8'hFF, 1'b0, 1'b0, -1);
    chk("bad_ferr", int'(ferr), 1);
    chk("bad_valid", int'(valid), 0);
    chk("bad_dout", int'(dout), int'(m_d));
    wait_cycles(20 * BT);
    rxd = 1'b1;
    wait_cycles(BT);
    chk("break_valid", int'(valid), 0);
    chk("break_ferr", int'(ferr), 1);
    send_frame(8'h12, 1'b1, 1'b0, -1);
    chk("post_break_ferr", int'(ferr), 1);
    do_rd();

    send_frame(8'h42, 1'b1, 1'b0, -1);
    send_frame(8'h81, 1'b1, 1'b1, -1);
    chk("rdwin_valid", int'(valid), 1);
    chk("rdwin_overrun", int'(overrun), 0);

    send_frame(8'hC3, 1'b1, 1'b0, 4);
    chk("post_rst_valid", int'(valid), 0);
    send_frame(8'h00, 1'b1, 1'b0, -1);
    chk("zero_ferr", int'(ferr), 0);
    do_rd();

    for (int k = 0; k < 4; k++) begin
      r = 8'($urandom);
      wait_cycles($urandom_range(0, 40));
      send_frame(r, 1'b1, 1'b0, -1);
      do_rd();
    end

    wait_cycles(50);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BIT_TIME, default 12'd433, meaning bit period minus one, in clk cycles (434 cycles per bit).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rxd  input  1  serial line, asynchronous to clk; idles high; 8N1, LSB first.
REQ-005 SHALL have port rd  input  1  single-cycle read strobe; acknowledges the held byte and clears flags.
REQ-006 SHALL have port dout  output  8  last received byte, held until overwritten.
REQ-007 SHALL have port valid  output  1  dout holds an unread byte.
REQ-008 SHALL have port overrun  output  1  sticky: a byte was overwritten before it was read.
REQ-009 SHALL have port ferr  output  1  sticky: the stop bit was sampled low.

Function
REQ-010 SHALL pass rxd through a two-flop synchronizer (rxd_s) before any use; both flops reset to 1.
REQ-011 SHALL use a 12-bit bit counter that clears on every state transition and otherwise increments; BIT_TIME SHALL fit in 12 bits.
REQ-012 SHALL implement states S_IDLE, S_START, S_DATA, S_STOP, S_WAIT.
REQ-013 S_IDLE: if rxd_s==0 -> S_START.
REQ-014 S_START: at counter==BIT_TIME>>1 (216), if rxd_s==1 -> S_IDLE (glitch, nothing recorded); else -> S_DATA with bit index 0.
REQ-015 S_DATA: at counter==BIT_TIME, shift register <= {rxd_s, shift[7:1]} and increment the bit index; after the 8th sample -> S_STOP.
REQ-016 S_STOP: at counter==BIT_TIME, if rxd_s==1, load dout from the shift register and set valid -> S_IDLE; if rxd_s==0, set ferr, leave dout and valid unchanged -> S_WAIT.
REQ-017 S_WAIT: stay until rxd_s==1, then -> S_IDLE; a held-low break SHALL NOT produce frames.
REQ-018 rd with valid==1 SHALL clear valid, overrun and ferr on the next edge; rd with valid==0 SHALL clear only overrun and ferr.
REQ-019 Byte completion while valid==1 and rd==0 SHALL overwrite dout, keep valid=1 and set overrun.
REQ-020 Byte completion in the same cycle as rd SHALL load dout, leave valid=1 and not set overrun; the completion wins over the clear.
REQ-021 A bad stop bit in the same cycle as rd SHALL leave ferr=1.
REQ-022 Latency: valid SHALL rise 2+1+217+8*434+434 = 4126 cycles (+/-1) after the rxd falling edge of the start bit.
REQ-023 Back-to-back frames SHALL be received with no idle time beyond the stop bit.

Reset
REQ-024 reset_n low SHALL immediately force state=S_IDLE, counter=0, bit index=0, shift=0, dout=8'h00, valid=0, overrun=0, ferr=0, sync flops=1.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte; after release, reception SHALL restart only at the next falling edge.

Verification
REQ-026 Single frame 0x55 at 434 cycles/bit -> valid=1 at 4126+/-1 cycles after the start edge, dout=8'h55, overrun=0, ferr=0; rd -> valid=0 next cycle.
REQ-027 A 100-cycle low pulse on idle rxd -> no valid, state returns to S_IDLE, next frame 0xA5 received correctly.
REQ-028 Back-to-back 0xA5 then 0x3C with no rd -> dout=8'h3C, valid=1, overrun=1; rd -> all three flags 0.
REQ-029 Frame 0xFF with stop bit low, then rxd held low for 20 bit times -> ferr=1, valid=0, dout unchanged, no further frames; after release a frame 0x12 gives valid=1, dout=8'h12, ferr still 1 until rd.
REQ-030 rd asserted in the exact completion cycle of a second byte 0x81 -> valid=1, dout=8'h81, overrun=0.
REQ-031 reset_n pulsed low during data bit 4 of 0xC3 -> all outputs 0 immediately; a subsequent frame 0x00 -> dout=8'h00, valid=1, ferr=0.
